// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: FSM state encoding, port indices and default widths shared by mem_access_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LSU = 1'b1;
  localparam int DEF_ADDR_W = 15;
  localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/arb2_pick.sv
// arb2_pick: combinational 2-way picker, req[1:0] (+ last under MEM_ARB_ROUND_ROBIN_EN) -> one-hot gnt[1:0]; port 1 wins ties unless MEM_ARB_ROUND_ROBIN_EN, where the port not granted last wins
module arb2_pick (
  input  logic [1:0] req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic       last,
`endif
  output logic [1:0] gnt
);
`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_comb gnt = &req ? (last ? 2'b01 : 2'b10) : req;
`else
  always_comb gnt = req[1] ? 2'b10 : req;
`endif
endmodule

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: serialises p0 fetch reads (p0_req/p0_addr/p0_ack) and p1 load/store (p1_req/p1_we/p1_addr/p1_wdata/p1_ack) onto one memory (mem_addr/mem_we/mem_wdata/mem_rdata), returning captured rdata; clk, async active-high reset; MEM_ARB_ROUND_ROBIN_EN selects round-robin ties
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  output logic              p0_ack,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t state, state_nxt;
  logic win;
  logic [1:0] gnt;
  arb2_pick u_pick (
    .req ({p1_req, p0_req}),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .last(win),
`endif
    .gnt (gnt)
  );
  always_comb begin
    state_nxt = state == IDLE ? (|gnt ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
    p0_ack = state == RESP && win == PORT_FETCH;
    p1_ack = state == RESP && win == PORT_LSU;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      win <= PORT_LSU;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_we <= 1'b0;
      rdata <= '0;
    end else if (state == IDLE && |gnt) begin
      win <= gnt[1];
      mem_addr <= gnt[1] ? p1_addr : p0_addr;
      mem_wdata <= gnt[1] ? p1_wdata : mem_wdata;
      mem_we <= gnt[1] & p1_we;
    end else if (state == ACCESS) begin
      mem_we <= 1'b0;
      rdata <= mem_we ? rdata : mem_rdata;
    end
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: transaction-level model plus directed checks for mem_access_arbiter
module tb_mem_access_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic p0_req = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [14:0] p0_addr = '0, p1_addr = '0;
  logic [31:0] p1_wdata = '0;
  logic p0_ack, p1_ack, mem_we;
  logic [31:0] rdata, mem_wdata, mem_rdata;
  logic [14:0] mem_addr;
  int ncmp = 0, nerr = 0;
  int cyc = 0;
  logic [31:0] mem [0:32767];
  logic [31:0] model_mem [0:32767];
  int we_q[$];

  always #5 clk = ~clk;

  mem_access_arbiter dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_ack(p0_ack),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_ack(p1_ack),
    .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial for (int i = 0; i < 32768; i++) begin
    mem[i] = i;
    model_mem[i] = i;
  end
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // Model: an access granted at edge g owns the memory lines during cycle g,
  // acks and commits during cycle g+1, and the next grant may happen at edge g+3.
  int g = -100;
  logic w = 1'b0, wr = 1'b0, m_last = 1'b1;
  logic [14:0] m_addr = '0;
  logic [31:0] m_wdata = '0, m_rdata = '0;
  always @(posedge clk or posedge reset)
    if (reset) begin
      g = -100;
      m_addr = '0;
      m_wdata = '0;
      m_rdata = '0;
      m_last = 1'b1;
      wr = 1'b0;
    end else begin
      cyc++;
      if (cyc == g + 1) begin
        if (wr) model_mem[m_addr] = m_wdata;
        else m_rdata = model_mem[m_addr];
      end
      if (cyc >= g + 3 && (p0_req || p1_req)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        w = (p0_req && p1_req) ? !m_last : p1_req;
`else
        w = p1_req;
`endif
        g = cyc;
        m_addr = w ? p1_addr : p0_addr;
        wr = w && p1_we;
        if (w) m_wdata = p1_wdata;
        m_last = w;
      end
    end

  always @(negedge clk)
    if (!reset) begin
      chk("p0_ack", 32'(p0_ack), 32'(cyc == g + 1 && !w));
      chk("p1_ack", 32'(p1_ack), 32'(cyc == g + 1 && w));
      chk("mem_we", 32'(mem_we), 32'(cyc == g && wr));
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("rdata", rdata, m_rdata);
      if (cyc == g && wr) chk("mem_wdata", mem_wdata, m_wdata);
      if (mem_we) we_q.push_back(cyc);
    end

  task automatic wait_ack(input bit port, output int c);
    c = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (port ? p1_ack : p0_ack) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) begin
      ncmp++;
      nerr++;
      $display("FAIL ack_timeout: port %0d got no ack within 30 cycles, expected one", port);
    end
  endtask

  task automatic access(input bit port, input bit we, input logic [14:0] a, input logic [31:0] d,
                        output int c, output logic [31:0] rd);
    if (port) begin
      p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = d;
    end else begin
      p0_req = 1'b1; p0_addr = a;
    end
    wait_ack(port, c);
    rd = rdata;
    @(posedge clk);
    #1;
    if (port) p1_req = 1'b0;
    else p0_req = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string n);
    chk({n, "_p0_ack"}, 32'(p0_ack), 32'd0);
    chk({n, "_p1_ack"}, 32'(p1_ack), 32'd0);
    chk({n, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({n, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({n, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({n, "_rdata"}, rdata, 32'd0);
  endtask

  initial begin
    int c0, c1, t0, n;
    logic [31:0] r0, r1;
    logic [3:0] seq;
    int ac [4];
    repeat (2) @(posedge clk);
    #1 chk_idle_outputs("reset");
    reset = 1'b0;

    @(posedge clk);
    #1 t0 = cyc;
    access(0, 0, 15'd5, 32'd0, c0, r0);
    chk("p0_latency", 32'(c0 - t0), 32'd2);
    chk("p0_rdata5", r0, 32'd5);
    chk("p0_addr_held", 32'(mem_addr), 32'd5);

    we_q.delete();
    access(1, 1, 15'd3, 32'hDEADBEEF, c1, r1);
    chk("write_pulses", 32'(we_q.size()), 32'd1);
    chk("write_mem", mem[3], 32'hDEADBEEF);
    chk("write_keeps_rdata", r1, 32'd5);
    access(0, 0, 15'd3, 32'd0, c0, r0);
    chk("readback", r0, 32'hDEADBEEF);

    pulse_reset();
    fork
      access(1, 0, 15'd7, 32'd0, c1, r1);
      access(0, 0, 15'd12, 32'd0, c0, r0);
    join
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("tie_order", 32'(c1 - c0), 32'd3);
`else
    chk("tie_order", 32'(c0 - c1), 32'd3);
`endif
    chk("tie_p1_rdata", r1, 32'd7);
    chk("tie_p0_rdata", r0, 32'd12);

    we_q.delete();
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 15'd20; p1_wdata = 32'h1111_2222;
    wait_ack(1, c0);
    @(posedge clk);
    #1 p1_addr = 15'd21; p1_wdata = 32'h3333_4444;
    wait_ack(1, c1);
    @(posedge clk);
    #1 p1_req = 1'b0;
    chk("b2b_ack_gap", 32'(c1 - c0), 32'd3);
    chk("b2b_pulses", 32'(we_q.size()), 32'd2);
    if (we_q.size() == 2) chk("b2b_pulse_gap", 32'(we_q[1] - we_q[0]), 32'd3);
    access(0, 0, 15'd20, 32'd0, c0, r0);
    chk("b2b_first", r0, 32'h1111_2222);
    access(0, 0, 15'd21, 32'd0, c0, r0);
    chk("b2b_second", r0, 32'h3333_4444);

    pulse_reset();
    p0_req = 1'b1; p0_addr = 15'd30;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 15'd31;
    n = 0;
    seq = '0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (p0_ack || p1_ack) begin
        seq[n] = p1_ack;
        ac[n] = cyc;
        n++;
      end
    end
    @(posedge clk);
    #1 p0_req = 1'b0; p1_req = 1'b0;
    chk("contend_acks", 32'(n), 32'd4);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("contend_seq", 32'(seq), 32'b1010);
`else
    chk("contend_seq", 32'(seq), 32'b1111);
`endif
    if (n == 4) for (int i = 1; i < 4; i++) chk("contend_gap", 32'(ac[i] - ac[i-1]), 32'd3);

    @(posedge clk);
    #1 p1_req = 1'b1; p1_we = 1'b1; p1_addr = 15'd9; p1_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #3 chk("mid_we_before", 32'(mem_we), 32'd1);
    chk("mid_addr_before", 32'(mem_addr), 32'd9);
    reset = 1'b1;
    #1 chk("mid_we_drop", 32'(mem_we), 32'd0);
    chk("mid_no_ack", 32'(p1_ack), 32'd0);
    p1_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("mid_mem_unchanged", mem[9], 32'd9);
    chk_idle_outputs("after_mid_reset");
    repeat (4) @(negedge clk);
    chk("no_late_ack", 32'(p0_ack | p1_ack), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  always @(negedge clk)
    if (p0_ack && p1_ack) begin
      ncmp++;
      nerr++;
      $display("FAIL dual_ack: p0_ack and p1_ack both 1, expected at most one");
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected finish");
    $fatal(1, "watchdog");
  end
endmodule
